// File: rtl/adder_pkg.sv
// rtl/adder_pkg.sv - shared defaults and op encoding for the pipelined adder
package adder_pkg;
  localparam int   DEF_WIDTH  = 32;
  localparam int   DEF_STAGES = 4;
  localparam logic OP_ADD     = 1'b0;
  localparam logic OP_SUB     = 1'b1;
endpackage

// File: rtl/adder_pipe_nbit_if.sv
// rtl/adder_pipe_nbit_if.sv - operand/result handshake bundle; Ovf exists only with ADDER_PIPE_OVF_EN
interface adder_pipe_nbit_if
  import adder_pkg::*;
#(
  parameter int WIDTH = DEF_WIDTH
);
  logic             in_valid;
  logic             in_ready;
  logic [WIDTH-1:0] A;
  logic [WIDTH-1:0] B;
  logic             Cin;
  logic             op_sub;
  logic             out_valid;
  logic             out_ready;
  logic [WIDTH-1:0] Sum;
  logic             Cout;
`ifdef ADDER_PIPE_OVF_EN
  logic             Ovf;
`endif

  modport master (
    output in_valid, A, B, Cin, op_sub, out_ready,
    input  in_ready, out_valid, Sum, Cout
`ifdef ADDER_PIPE_OVF_EN
    , input Ovf
`endif
  );

  modport slave (
    input  in_valid, A, B, Cin, op_sub, out_ready,
    output in_ready, out_valid, Sum, Cout
`ifdef ADDER_PIPE_OVF_EN
    , output Ovf
`endif
  );
endinterface

// File: rtl/adder_chunk.sv
// rtl/adder_chunk.sv - combinational CHUNK-bit ripple slice; c_msb port only with ADDER_PIPE_OVF_EN
module adder_chunk #(
  parameter int CHUNK = 8
) (
  input  logic [CHUNK-1:0] a,
  input  logic [CHUNK-1:0] b,
  input  logic             cin,
  output logic [CHUNK-1:0] sum,
  output logic             cout
`ifdef ADDER_PIPE_OVF_EN
  , output logic           c_msb
`endif
);
  logic [CHUNK:0] c;

  always_comb begin
    c    = '0;
    sum  = '0;
    c[0] = cin;
    for (int i = 0; i < CHUNK; i++) begin
      sum[i]  = a[i] ^ b[i] ^ c[i];
      c[i+1]  = (a[i] & b[i]) | (c[i] & (a[i] ^ b[i]));
    end
  end

  assign cout = c[CHUNK];
`ifdef ADDER_PIPE_OVF_EN
  assign c_msb = c[CHUNK-1];
`endif
endmodule

// File: rtl/adder_pipe_nbit.sv
// rtl/adder_pipe_nbit.sv - pipelined WIDTH-bit add/sub, STAGES carry slices; optional Ovf via ADDER_PIPE_OVF_EN
module adder_pipe_nbit
  import adder_pkg::*;
#(
  parameter int WIDTH  = DEF_WIDTH,
  parameter int STAGES = DEF_STAGES
) (
  input logic             clk,
  input logic             rst_n,
  adder_pipe_nbit_if.slave bus
);
  localparam int CHUNK = WIDTH / STAGES;

  logic              adv;
  logic [WIDTH-1:0]  b_eff;
  logic              cin0;

  // word_q[k] is a right-shifting skew line: the low bits still hold unconsumed
  // A slices while finished sum slices are inserted at the top, so after the
  // last stage it holds the aligned Sum.
  logic [WIDTH-1:0]  word_q [STAGES];
  logic [WIDTH-1:0]  b_q    [STAGES];
  logic [WIDTH-1:0]  a_in   [STAGES];
  logic [WIDTH-1:0]  b_in   [STAGES];
  logic [WIDTH-1:0]  word_d [STAGES];
  logic [WIDTH-1:0]  b_d    [STAGES];
  logic [CHUNK-1:0]  s_chunk [STAGES];
  logic [STAGES-1:0] c_in;
  logic [STAGES-1:0] v_in;
  logic [STAGES-1:0] c_out;
  logic [STAGES-1:0] cy_q;
  logic [STAGES-1:0] vld_q;
`ifdef ADDER_PIPE_OVF_EN
  logic [STAGES-1:0] c_msb;
  logic              ovf_q;
`endif

  assign adv          = ~vld_q[STAGES-1] | bus.out_ready;
  assign bus.in_ready = adv;
  assign b_eff        = (bus.op_sub == OP_SUB) ? ~bus.B : bus.B;
  assign cin0         = (bus.op_sub == OP_SUB) ? 1'b1 : bus.Cin;

  for (genvar k = 0; k < STAGES; k++) begin : g_stage
    if (k == 0) begin : g_head
      assign a_in[k] = bus.A;
      assign b_in[k] = b_eff;
      assign c_in[k] = cin0;
      assign v_in[k] = bus.in_valid;
    end else begin : g_tail
      assign a_in[k] = word_q[k-1];
      assign b_in[k] = b_q[k-1];
      assign c_in[k] = cy_q[k-1];
      assign v_in[k] = vld_q[k-1];
    end

    adder_chunk #(.CHUNK(CHUNK)) u_chunk (
      .a    (a_in[k][CHUNK-1:0]),
      .b    (b_in[k][CHUNK-1:0]),
      .cin  (c_in[k]),
      .sum  (s_chunk[k]),
      .cout (c_out[k])
`ifdef ADDER_PIPE_OVF_EN
      , .c_msb(c_msb[k])
`endif
    );

    assign word_d[k] = (a_in[k] >> CHUNK) | (WIDTH'(s_chunk[k]) << (WIDTH - CHUNK));
    assign b_d[k]    = b_in[k] >> CHUNK;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int k = 0; k < STAGES; k++) begin
        word_q[k] <= '0;
        b_q[k]    <= '0;
      end
      cy_q  <= '0;
      vld_q <= '0;
    end else if (adv) begin
      for (int k = 0; k < STAGES; k++) begin
        word_q[k] <= word_d[k];
        b_q[k]    <= b_d[k];
      end
      cy_q  <= c_out;
      vld_q <= v_in;
    end
  end

  assign bus.out_valid = vld_q[STAGES-1];
  assign bus.Sum       = word_q[STAGES-1];
  assign bus.Cout      = cy_q[STAGES-1];

`ifdef ADDER_PIPE_OVF_EN
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      ovf_q <= 1'b0;
    end else if (adv) begin
      ovf_q <= c_msb[STAGES-1] ^ c_out[STAGES-1];
    end
  end

  assign bus.Ovf = ovf_q;
`endif
endmodule
